// File: rtl/sprite_loader_pkg.sv
// Shared types and constants for the sprite RAM loader.
// State encoding, sprite selector values and per-sprite RAM depths.
package sprite_loader_pkg;

    localparam int TOTAL_W     = 24;
    localparam int NUM_SPRITES = 7;

    typedef enum logic [3:0] {
        S_SEL,
        S_FRAMES,
        S_WIDTH,
        S_HEIGHT,
        S_CALC,
        S_DATA,
        S_DRAIN,
        S_CSUM,
        S_DONE
    } loader_state_t;

    typedef enum logic [2:0] {
        SEL_FORWARD  = 3'd0,
        SEL_BACKWARD = 3'd1,
        SEL_STAND    = 3'd2,
        SEL_ATTACK   = 3'd3,
        SEL_DEFENSE  = 3'd4,
        SEL_HURT     = 3'd5,
        SEL_DIE      = 3'd6
    } sprite_sel_t;

    // Pixel capacity of each sprite RAM, indexed by sprite_sel_t.
    localparam logic [TOTAL_W-1:0] DEPTH [NUM_SPRITES] = '{
        24'd17680, 24'd16695, 24'd16893, 24'd15000, 24'd2244, 24'd9870, 24'd24115
    };

    function automatic logic [TOTAL_W-1:0] depth_of(input logic [2:0] sel);
        logic [TOTAL_W-1:0] depth;
        depth = '0;
        if (sel < 3'(NUM_SPRITES)) begin
            depth = DEPTH[sel];
        end
        return depth;
    endfunction

endpackage

// File: rtl/sprite_ram_loader.sv
// Streams sprite records (sel, frames, width, height, pixels) into one of seven sprite RAMs.
// Define LOADER_CHECKSUM_EN to expect a trailing mod-256 checksum byte on every nonempty record.
module sprite_ram_loader
    import sprite_loader_pkg::*;
#(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [2:0]        wr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t AFTER_PAYLOAD = S_CSUM;
`else
    localparam loader_state_t AFTER_PAYLOAD = S_DONE;
`endif

    loader_state_t state_q, state_d;

    logic                 live_q;
    logic [DATA_W-1:0]    sel_q;
    logic [DATA_W-1:0]    frames_q;
    logic [DATA_W-1:0]    width_q;
    logic [DATA_W-1:0]    height_q;
    logic [TOTAL_W-1:0]   total_q;
    logic [TOTAL_W-1:0]   cnt_q;
    logic                 reject_q;
    logic                 wr_en_q;
    logic [2:0]           wr_sel_q;
    logic [ADDR_W-1:0]    wr_addr_q;
    logic [DATA_W-1:0]    wr_data_q;
    logic                 csum_bad;

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]    csum_q;
    logic                 csum_bad_q;
    assign csum_bad = csum_bad_q;
`else
    assign csum_bad = 1'b0;
`endif

    logic                 accept;
    logic                 last_byte;
    logic                 sel_ok;
    logic                 record_ok;
    logic [TOTAL_W-1:0]   total_calc;

    assign total_calc = TOTAL_W'(frames_q) * TOTAL_W'(width_q) * TOTAL_W'(height_q);
    assign sel_ok     = (sel_q <= DATA_W'(NUM_SPRITES - 1));
    assign record_ok  = sel_ok && (total_calc != '0) && (total_calc <= depth_of(sel_q[2:0]));
    assign last_byte  = (cnt_q == total_q - TOTAL_W'(1));
    assign accept     = in_valid && in_ready;

    // live_q keeps in_ready low until the first edge after reset release.
    always_comb begin
        in_ready = 1'b0;
        if (live_q) begin
            case (state_q)
                S_SEL, S_FRAMES, S_WIDTH, S_HEIGHT, S_DATA, S_DRAIN, S_CSUM: in_ready = 1'b1;
                default:                                                     in_ready = 1'b0;
            endcase
        end
    end

    assign busy    = (state_q != S_SEL);
    assign done    = (state_q == S_DONE);
    assign err     = done && (reject_q || csum_bad);
    assign wr_en   = wr_en_q;
    assign wr_sel  = wr_sel_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_SEL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_SEL:    if (accept) state_d = S_FRAMES;
            S_FRAMES: if (accept) state_d = S_WIDTH;
            S_WIDTH:  if (accept) state_d = S_HEIGHT;
            S_HEIGHT: if (accept) state_d = S_CALC;
            S_CALC: begin
                if (record_ok) begin
                    state_d = S_DATA;
                end else if (total_calc != '0) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DATA, S_DRAIN: if (accept && last_byte) state_d = AFTER_PAYLOAD;
`ifdef LOADER_CHECKSUM_EN
            S_CSUM:   if (accept) state_d = S_DONE;
`endif
            S_DONE:   state_d = S_SEL;
            default:  state_d = S_SEL;
        endcase
    end

    // Header capture, payload counting and the one-cycle-late RAM write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q    <= 1'b0;
            sel_q     <= '0;
            frames_q  <= '0;
            width_q   <= '0;
            height_q  <= '0;
            total_q   <= '0;
            cnt_q     <= '0;
            reject_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_sel_q  <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            live_q  <= 1'b1;
            wr_en_q <= 1'b0;
            case (state_q)
                S_SEL: begin
                    if (accept) begin
                        sel_q    <= in_data;
                        wr_sel_q <= in_data[2:0];
                    end
                end
                S_FRAMES: if (accept) frames_q <= in_data;
                S_WIDTH:  if (accept) width_q  <= in_data;
                S_HEIGHT: if (accept) height_q <= in_data;
                S_CALC: begin
                    total_q  <= total_calc;
                    reject_q <= !record_ok;
                    cnt_q    <= '0;
                end
                S_DATA, S_DRAIN: begin
                    if (accept) begin
                        cnt_q <= last_byte ? '0 : cnt_q + TOTAL_W'(1);
                        if (state_q == S_DATA) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= ADDR_W'(cnt_q);
                            wr_data_q <= in_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running payload sum, restarted per record, compared with the trailing byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q     <= '0;
            csum_bad_q <= 1'b0;
        end else begin
            case (state_q)
                S_CALC: begin
                    csum_q     <= '0;
                    csum_bad_q <= 1'b0;
                end
                S_DATA, S_DRAIN: if (accept) csum_q <= csum_q + in_data;
                S_CSUM:          if (accept) csum_bad_q <= (in_data != csum_q);
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_sprite_ram_loader.sv
// Directed self-checking bench for sprite_ram_loader.
// Exercises accepted, oversize, invalid, empty, gapped and reset-interrupted records; checksum cases with LOADER_CHECKSUM_EN.
module tb_sprite_ram_loader;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              wr_en;
    logic [2:0]        wr_sel;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              err;

    int tests_run    = 0;
    int tests_failed = 0;
    int write_count  = 0;
    int done_count   = 0;
    logic last_err   = 1'b0;
    logic [2:0] exp_sel = '0;
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [DATA_W-1:0] exp_data_q[$];

    sprite_ram_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #10 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Every RAM write is matched against the next expected address/data pair.
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            write_count++;
            if (exp_addr_q.size() == 0) begin
                checkOutput("unexpected_write", 32'(wr_addr), 32'hFFFF_FFFF);
            end else begin
                checkOutput("wr_addr", 32'(wr_addr), 32'(exp_addr_q.pop_front()));
                checkOutput("wr_data", 32'(wr_data), 32'(exp_data_q.pop_front()));
                checkOutput("wr_sel", 32'(wr_sel), 32'(exp_sel));
            end
        end
        if (rst_n && done) begin
            done_count++;
            last_err = err;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int  gap;
        bit  taken;
        logic rdy;
        gap   = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        taken = 1'b0;
        repeat (gap) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 50 && !taken; t++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) taken = 1'b1;
        end
        in_valid = 1'b0;
        if (!taken) checkOutput("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic applyStimulus(input logic [7:0] sel, input logic [7:0] frames, input logic [7:0] width,
                                 input logic [7:0] height, input int max_gap, input bit expect_ok,
                                 input bit bad_csum, input string name);
        int          total;
        int          done_before;
        logic [7:0]  px;
        logic [7:0]  sum;
        total       = int'(frames) * int'(width) * int'(height);
        exp_sel     = sel[2:0];
        write_count = 0;
        done_before = done_count;
        sum         = '0;
        send_byte(sel, max_gap);
        send_byte(frames, max_gap);
        send_byte(width, max_gap);
        send_byte(height, max_gap);
        for (int i = 0; i < total; i++) begin
            px = 8'(i * 7 + (i >> 8) + 3);
            if (expect_ok) begin
                exp_addr_q.push_back(ADDR_W'(i));
                exp_data_q.push_back(px);
            end
            sum = sum + px;
            send_byte(px, max_gap);
        end
`ifdef LOADER_CHECKSUM_EN
        if (total != 0) send_byte(bad_csum ? sum + 8'd1 : sum, max_gap);
`endif
        for (int t = 0; t < 10 && done_count == done_before; t++) @(negedge clk);
        @(posedge clk);
        #1;
        checkOutput({name, "_done"}, 32'(done_count - done_before), 32'd1);
        checkOutput({name, "_err"}, 32'(last_err), 32'(!expect_ok || bad_csum));
        checkOutput({name, "_writes"}, 32'(write_count), expect_ok ? 32'(total) : 32'd0);
        checkOutput({name, "_leftover"}, 32'(exp_addr_q.size()), 32'd0);
        exp_addr_q.delete();
        exp_data_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int done_before;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
        checkOutput("rst_wr_sel", 32'(wr_sel), 32'd0);
        checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
        checkOutput("rst_wr_data", 32'(wr_data), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        applyStimulus(8'd4, 8'd1, 8'd44, 8'd51, 0, 1'b1, 1'b0, "defense");
        applyStimulus(8'd4, 8'd2, 8'd44, 8'd51, 0, 1'b0, 1'b0, "oversize");
        applyStimulus(8'd9, 8'd1, 8'd2, 8'd2, 0, 1'b0, 1'b0, "badsel");

        // Empty record: one S_CALC cycle, then S_DONE with err.
        write_count = 0;
        send_byte(8'd0, 0);
        send_byte(8'd1, 0);
        send_byte(8'd0, 0);
        send_byte(8'd5, 0);
        @(negedge clk);
        checkOutput("calc_in_ready", 32'(in_ready), 32'd0);
        checkOutput("calc_done", 32'(done), 32'd0);
        checkOutput("calc_busy", 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("empty_done", 32'(done), 32'd1);
        checkOutput("empty_err", 32'(err), 32'd1);
        checkOutput("empty_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        checkOutput("empty_back_idle", 32'(busy), 32'd0);
        checkOutput("empty_writes", 32'(write_count), 32'd0);
        @(posedge clk);
        #1;

        applyStimulus(8'd2, 8'd1, 8'd37, 8'd51, 3, 1'b1, 1'b0, "stand_gaps");

        // Reset after 100 payload bytes of a defense record.
        exp_sel     = 3'd4;
        write_count = 0;
        done_before = done_count;
        send_byte(8'd4, 0);
        send_byte(8'd1, 0);
        send_byte(8'd44, 0);
        send_byte(8'd51, 0);
        for (int i = 0; i < 100; i++) begin
            exp_addr_q.push_back(ADDR_W'(i));
            exp_data_q.push_back(8'(i + 40));
            send_byte(8'(i + 40), 0);
        end
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("midrst_wr_en", 32'(wr_en), 32'd0);
        checkOutput("midrst_wr_sel", 32'(wr_sel), 32'd0);
        checkOutput("midrst_wr_addr", 32'(wr_addr), 32'd0);
        checkOutput("midrst_wr_data", 32'(wr_data), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_err", 32'(err), 32'd0);
        checkOutput("midrst_writes", 32'(write_count), 32'd100);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midrst_release_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst_no_done", 32'(done_count - done_before), 32'd0);
        @(posedge clk);
        #1;

        applyStimulus(8'd5, 8'd1, 8'd2, 8'd2, 1, 1'b1, 1'b0, "hurt");

`ifdef LOADER_CHECKSUM_EN
        applyStimulus(8'd3, 8'd1, 8'd4, 8'd4, 0, 1'b1, 1'b0, "csum_ok");
        applyStimulus(8'd3, 8'd1, 8'd4, 8'd4, 1, 1'b1, 1'b1, "csum_bad");
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sprite_ram_loader.md
SPRITE_RAM_LOADER -- requirements
Module: sprite_ram_loader

Interface
REQ-001 Parameter ADDR_W, default 19, sprite RAM address width.
REQ-002 Parameter DATA_W, default 8, palette-index pixel width.
REQ-003 Clk  input  1  system clock (50 MHz); one clock domain only.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 in_data  input  DATA_W  stream byte.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  loader accepts a byte; transfer occurs on Clk edge with in_valid && in_ready.
REQ-008 wr_en  output  1  one-cycle write strobe to the selected sprite RAM.
REQ-009 wr_sel  output  3  target RAM: 0 forward, 1 backward, 2 stand, 3 attack, 4 defense, 5 hurt, 6 die.
REQ-010 wr_addr  output  ADDR_W  write address.
REQ-011 wr_data  output  DATA_W  write pixel.
REQ-012 busy  output  1  high while not in S_SEL.
REQ-013 done  output  1  one-cycle pulse at the end of each record.
REQ-014 err  output  1  valid with done; record rejected or corrupt.

Function
REQ-015 Record format, in order: sel byte, frames byte, width byte, height byte, then frames*width*height pixel bytes in the order frame, row, column.
REQ-016 The FSM SHALL use these states: S_SEL, S_FRAMES, S_WIDTH, S_HEIGHT, S_CALC, S_DATA, S_DRAIN, S_CSUM, S_DONE.
- S_SEL -> S_FRAMES -> S_WIDTH -> S_HEIGHT, advancing on each accepted byte.
- S_HEIGHT -> S_CALC on acceptance.
REQ-017 S_CALC SHALL last exactly one cycle, with in_ready low, and SHALL register total = frames*width*height in 24 bits.
REQ-018 Record acceptance SHALL be decided in S_CALC:
- accepted if sel <= 6, total != 0 and total <= DEPTH[sel];
- an accepted record goes to S_DATA;
- a rejected record with total != 0 goes to S_DRAIN;
- a rejected record with total == 0 goes to S_DONE.
REQ-019 In S_DATA, each accepted byte SHALL produce, on the following cycle:
- wr_en = 1;
- wr_addr = running count, starting at 0;
- wr_data = the byte.
Write latency is one cycle.
REQ-020 The address count SHALL increment only on accepted bytes; in_valid gaps SHALL neither skip nor repeat addresses.
REQ-021 S_DRAIN SHALL consume exactly total bytes with wr_en held at 0.
REQ-022 After the last payload byte, the FSM SHALL go to S_CSUM if LOADER_CHECKSUM_EN is defined, else to S_DONE.
REQ-023 S_DONE SHALL last one cycle, with in_ready = 0, done = 1 and err = rejected || checksum mismatch, then return to S_SEL.
REQ-024 in_ready SHALL be 1 in S_SEL, S_FRAMES, S_WIDTH, S_HEIGHT, S_DATA, S_DRAIN and S_CSUM, and 0 otherwise.
REQ-025 The payload counter SHALL be 24-bit and compare against total - 1 to detect the last byte; wr_addr SHALL be its low ADDR_W bits.
REQ-026 wr_sel SHALL hold the registered sel for the whole record.

Reset
REQ-027 While Reset is low, the block SHALL force state S_SEL and zero all counters and the checksum.
REQ-028 Reset values SHALL be: in_ready 0, wr_en 0, wr_sel 0, wr_addr 0, wr_data 0, busy 0, done 0, err 0.
REQ-029 A reset mid-record SHALL abandon the record with no done pulse; in_ready SHALL go high on the first Clk edge after Reset rises.

Configuration
REQ-030 Macro LOADER_CHECKSUM_EN controls a trailing checksum byte.
- Defined: each record carries one trailing byte equal to the mod-256 sum of all payload bytes. S_CSUM accepts that byte and flags a mismatch into err. A drained record also reads its checksum byte.
- Undefined: there is no trailing byte, S_CSUM is unreachable and its logic is absent.

Structure
REQ-031 Package sprite_loader_pkg SHALL hold:
- the loader_state_t enum;
- the sprite_sel_t values;
- the DEPTH table: 17680, 16695, 16893, 15000, 2244, 9870, 24115.
REQ-032 The block SHALL be a single module with no sub-modules; the multiply is inline and registered in S_CALC.

Verification
REQ-033 Defense record (sel 4, frames 1, width 44, height 51), 2244 bytes streamed -> 2244 wr_en pulses, addresses 0..2243, wr_sel 4, done with err 0.
REQ-034 Oversize defense record (sel 4, frames 2, width 44, height 51; total 4488 > 2244) -> 4488 bytes consumed, no wr_en, done with err 1.
REQ-035 Invalid sel 9 with 1x2x2 dims -> 4 bytes drained, done with err 1; zero width -> done in the cycle after S_CALC with err 1.
REQ-036 Stand record 1x37x51 with random in_valid gaps -> addresses contiguous 0..1886 with data matching input order.
REQ-037 Reset low at payload byte 100 -> outputs at reset values, no done pulse; a following 1x2x2 hurt record loads at addresses 0..3.
REQ-038 With LOADER_CHECKSUM_EN: correct checksum -> err 0; checksum+1 -> err 1, with all pixel writes still performed.
